// File: rtl/d_sa_cache_ctrl.sv
// d_sa_cache_ctrl
// 2-way set-associative, write-through, no-write-allocate data cache
// controller that sits between a core load/store port and a 128-bit line
// memory. Read hits are answered from local line storage one cycle after
// accept. Read misses fetch a whole line. Every store is forwarded to
// memory as a single 32-bit word write.
//
// Ports
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   cpu_req_valid/we    : core request strobe and store flag
//   cpu_addr            : word address {tag, index, word_offset}
//   cpu_wdata           : store data
//   cpu_ready           : controller idle, a request may be accepted
//   cpu_resp_valid      : one-cycle completion pulse
//   cpu_rdata           : load data, valid with cpu_resp_valid
//   r_mem_req_out       : one-cycle line read request
//   w_mem_req_out       : one-cycle word write request
//   mem_addr_out        : {tag, index} line address
//   data_mem_wr_data    : store word sent to memory
//   blockoffset_out     : word within the line for the write
//   mem_comp_in         : memory completion (sticky-high after first access)
//   mem_data_in         : line read data
module d_sa_cache_ctrl #(
  parameter int TAG_W   = 6,
  parameter int INDEX_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_req_valid,
  input  logic                       cpu_we,
  input  logic [TAG_W+INDEX_W+1:0]   cpu_addr,
  input  logic [31:0]                cpu_wdata,
  output logic                       cpu_ready,
  output logic                       cpu_resp_valid,
  output logic [31:0]                cpu_rdata,
  output logic                       r_mem_req_out,
  output logic                       w_mem_req_out,
  output logic [TAG_W+INDEX_W-1:0]   mem_addr_out,
  output logic [31:0]                data_mem_wr_data,
  output logic [1:0]                 blockoffset_out,
  input  logic                       mem_comp_in,
  input  logic [127:0]               mem_data_in
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP} state_t;

  state_t state_q, state_d;

  // Per-set storage: valid/tag/line per way, one LRU bit naming the victim.
  logic [1:0][SETS-1:0] valid_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [2][SETS];
  logic [127:0]         line_q [2][SETS];

  // Registered request and memory-side outputs.
  logic                     hit_resp_q;
  logic [31:0]              cpu_rdata_q;
  logic [TAG_W-1:0]         req_tag_q;
  logic [INDEX_W-1:0]       req_idx_q;
  logic [1:0]               req_off_q;
  logic [TAG_W+INDEX_W-1:0] mem_addr_q;
  logic [31:0]              wdata_q;
  logic [1:0]               boff_q;

  function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] off);
    word_sel = line[{off, 5'b0} +: 32];
  endfunction

  // Address decode of the incoming request.
  logic [TAG_W-1:0]   a_tag;
  logic [INDEX_W-1:0] a_idx;
  logic [1:0]         a_off;
  assign a_tag = cpu_addr[TAG_W+INDEX_W+1 -: TAG_W];
  assign a_idx = cpu_addr[2 +: INDEX_W];
  assign a_off = cpu_addr[1:0];

  logic [1:0] way_hit;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
      assign way_hit[gi] = valid_q[gi][a_idx] && (tag_q[gi][a_idx] == a_tag);
    end
  endgenerate

  // At most one way can match, so way 1's match bit is the hit way index.
  logic hit, hit_way, accept, victim, fill;
  assign hit     = |way_hit;
  assign hit_way = way_hit[1];
  assign accept  = cpu_req_valid && (state_q == IDLE);
  assign victim  = lru_q[req_idx_q];
  assign fill    = (state_q == RD_WAIT) && mem_comp_in;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. Load hits stay in IDLE so hits can stream one per cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) begin
                 if (cpu_we)   state_d = WR_REQ;
                 else if (!hit) state_d = RD_REQ;
               end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (mem_comp_in) state_d = RESP;
      WR_REQ:  state_d = WR_WAIT;
      WR_WAIT: if (mem_comp_in) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cpu_ready        = (state_q == IDLE);
    r_mem_req_out    = (state_q == RD_REQ);
    w_mem_req_out    = (state_q == WR_REQ);
    cpu_resp_valid   = hit_resp_q || (state_q == RESP);
    cpu_rdata        = cpu_rdata_q;
    mem_addr_out     = mem_addr_q;
    data_mem_wr_data = wdata_q;
    blockoffset_out  = boff_q;
  end

  // Control state: valid/LRU bits, request capture, response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      lru_q       <= '0;
      hit_resp_q  <= 1'b0;
      cpu_rdata_q <= '0;
      req_tag_q   <= '0;
      req_idx_q   <= '0;
      req_off_q   <= '0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      boff_q      <= '0;
    end else begin
      hit_resp_q <= 1'b0;
      if (accept) begin
        if (!cpu_we && hit) begin
          hit_resp_q     <= 1'b1;
          cpu_rdata_q    <= word_sel(line_q[hit_way][a_idx], a_off);
          lru_q[a_idx]   <= ~hit_way;
        end else begin
          req_tag_q  <= a_tag;
          req_idx_q  <= a_idx;
          req_off_q  <= a_off;
          mem_addr_q <= {a_tag, a_idx};
          if (cpu_we) begin
            wdata_q <= cpu_wdata;
            boff_q  <= a_off;
            // Store hit refreshes recency; store miss leaves the set untouched.
            if (hit) lru_q[a_idx] <= ~hit_way;
          end
        end
      end
      if (fill) begin
        valid_q[victim][req_idx_q] <= 1'b1;
        lru_q[req_idx_q]           <= ~victim;
        cpu_rdata_q                <= word_sel(mem_data_in, req_off_q);
      end
    end
  end

  // Tag and line arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept && cpu_we && hit)
      line_q[hit_way][a_idx][{a_off, 5'b0} +: 32] <= cpu_wdata;
    if (fill) begin
      line_q[victim][req_idx_q] <= mem_data_in;
      tag_q[victim][req_idx_q]  <= req_tag_q;
    end
  end

endmodule

// File: tb/tb_d_sa_cache_ctrl.sv
module tb_d_sa_cache_ctrl;

  logic         clk;
  logic         reset;
  logic         cpu_req_valid;
  logic         cpu_we;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_rdata;
  logic         r_mem_req_out;
  logic         w_mem_req_out;
  logic [7:0]   mem_addr_out;
  logic [31:0]  data_mem_wr_data;
  logic [1:0]   blockoffset_out;
  logic         mem_comp_in;
  logic [127:0] mem_data_in;

  d_sa_cache_ctrl #(.TAG_W(6), .INDEX_W(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_valid(cpu_req_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
    .cpu_rdata(cpu_rdata), .r_mem_req_out(r_mem_req_out), .w_mem_req_out(w_mem_req_out),
    .mem_addr_out(mem_addr_out), .data_mem_wr_data(data_mem_wr_data),
    .blockoffset_out(blockoffset_out), .mem_comp_in(mem_comp_in), .mem_data_in(mem_data_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [127:0] mem_arr [256];
  assign mem_data_in = mem_arr[mem_addr_out];
  int next_delay = 0;
  int comp_cnt   = 0;

  // ---------------- reference model ----------------
  // Word-addressed memory image, and per-set recency list of cached tags.
  logic [31:0] ref_mem [1024];
  logic [5:0]  mru_tag [4];
  logic [5:0]  lru_tag [4];
  int          n_valid [4];

  function automatic bit model_hit(input int s, input logic [5:0] t);
    return (n_valid[s] >= 1 && mru_tag[s] == t) || (n_valid[s] == 2 && lru_tag[s] == t);
  endfunction

  // Make t most recent; a new tag pushes the oldest one out.
  task automatic model_touch(input int s, input logic [5:0] t, input bit is_new);
    if (is_new) begin
      lru_tag[s] = mru_tag[s];
      mru_tag[s] = t;
      if (n_valid[s] < 2) n_valid[s]++;
    end else if (mru_tag[s] != t) begin
      lru_tag[s] = mru_tag[s];
      mru_tag[s] = t;
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 4; s++) n_valid[s] = 0;
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          lat;
    int          t0;
    logic [9:0]  addr;
  } exp_t;

  typedef struct {
    bit          we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [1:0]  off;
  } mreq_t;

  exp_t  resp_q[$];
  mreq_t mreq_q[$];

  // Memory responder: checks each request against the expectation queue,
  // performs writes, and drives mem_comp_in (optionally late).
  initial begin
    mem_comp_in = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mem_comp_in = 1'b0;
        comp_cnt    = 0;
      end else if (r_mem_req_out || w_mem_req_out) begin
        mreq_t m;
        chk("rw_exclusive", {r_mem_req_out, w_mem_req_out} == 2'b11, 1'b0);
        if (mreq_q.size() == 0) begin
          chk("unexpected_mem_req", 1'b1, 1'b0);
        end else begin
          m = mreq_q.pop_front();
          chk("mem_req_kind", w_mem_req_out, m.we);
          chk("mem_addr_out", mem_addr_out, m.addr);
          if (m.we) begin
            chk("data_mem_wr_data", data_mem_wr_data, m.data);
            chk("blockoffset_out", blockoffset_out, m.off);
            mem_arr[mem_addr_out][blockoffset_out*32 +: 32] = data_mem_wr_data;
          end
        end
        comp_cnt    = next_delay;
        mem_comp_in = (next_delay == 0);
      end else if (comp_cnt > 0) begin
        comp_cnt--;
      end else begin
        mem_comp_in = 1'b1;
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cpu_resp_valid) begin
        exp_t e;
        if (resp_q.size() == 0) begin
          chk("spurious_resp", 1'b1, 1'b0);
        end else begin
          e = resp_q.pop_front();
          $display("[TB] resp %s addr=%03h rdata=%08h lat=%0d", e.is_load ? "LD" : "ST",
                   e.addr, cpu_rdata, cyc - e.t0);
          chk("resp_latency", cyc - e.t0, e.lat);
          if (e.is_load) chk("cpu_rdata", cpu_rdata, e.data);
        end
      end
    end
  end

  // Issue one request; expectations come from the reference model.
  task automatic issue(input bit we, input logic [9:0] addr, input logic [31:0] wd, input int d);
    int w;
    bit h;
    exp_t e;
    mreq_t m;
    @(negedge clk);
    w = 0;
    while (!cpu_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!cpu_ready) begin
      chk("ready_timeout", 1'b0, 1'b1);
      return;
    end
    h = model_hit(int'(addr[3:2]), addr[9:4]);
    e.is_load = !we;
    e.addr    = addr;
    e.t0      = cyc;
    e.data    = we ? 32'h0 : ref_mem[addr];
    e.lat     = (!we && h) ? 1 : 3 + d;
    if (we) ref_mem[addr] = wd;
    if (h) model_touch(int'(addr[3:2]), addr[9:4], 1'b0);
    else if (!we) model_touch(int'(addr[3:2]), addr[9:4], 1'b1);
    if (we || !h) begin
      m.we = we; m.addr = addr[9:2]; m.data = wd; m.off = addr[1:0];
      mreq_q.push_back(m);
      next_delay = d;
    end
    resp_q.push_back(e);
    cpu_req_valid = 1'b1;
    cpu_we        = we;
    cpu_addr      = addr;
    cpu_wdata     = wd;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((resp_q.size() != 0 || mreq_q.size() != 0 || !cpu_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_timeout", w < 200, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ready"}, cpu_ready, 1'b1);
    chk({tag, "_cpu_resp_valid"}, cpu_resp_valid, 1'b0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'h0);
    chk({tag, "_r_mem_req"}, r_mem_req_out, 1'b0);
    chk({tag, "_w_mem_req"}, w_mem_req_out, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr_out, 8'h0);
    chk({tag, "_wr_data"}, data_mem_wr_data, 32'h0);
    chk({tag, "_blockoffset"}, blockoffset_out, 2'h0);
  endtask

  initial begin
    reset         = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_we        = 1'b0;
    cpu_addr      = '0;
    cpu_wdata     = '0;
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 4; k++) ref_mem[i*4+k] = mem_arr[i][k*32 +: 32];
    end
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Cold load miss, then four back-to-back hits on the same word.
    issue(1'b0, 10'h0A5, 32'h0, 0);
    drain();
    for (int i = 0; i < 4; i++) issue(1'b0, 10'h0A5, 32'h0, 0);
    drain();

    // Three tags into set 2: tag 3 evicts tag 1, tag 2 survives.
    issue(1'b0, 10'h018, 32'h0, 0);
    issue(1'b0, 10'h028, 32'h0, 0);
    issue(1'b0, 10'h038, 32'h0, 0);
    issue(1'b0, 10'h029, 32'h0, 0);
    issue(1'b0, 10'h01B, 32'h0, 0);
    drain();

    // Store hit followed by a load hit of the stored word.
    issue(1'b1, 10'h0A6, 32'hDEADBEEF, 0);
    issue(1'b0, 10'h0A6, 32'h0, 0);
    // Store miss followed by a refilling load.
    issue(1'b1, 10'h3F1, 32'h12345678, 0);
    issue(1'b0, 10'h3F1, 32'h0, 0);
    // Slow memory completion.
    issue(1'b1, 10'h2C3, 32'hCAFEF00D, 2);
    issue(1'b0, 10'h2C3, 32'h0, 1);
    drain();

    // Randomized traffic over a small tag space to mix hits and misses.
    for (int i = 0; i < 300; i++) begin
      bit we;
      logic [9:0] a;
      int d;
      we = ($urandom_range(0, 3) == 0);
      a  = {6'($urandom_range(0, 5)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      issue(we, a, $urandom, d);
    end
    drain();

    // Reset while waiting for a line fill aborts the transaction.
    issue(1'b0, 10'h1D6, 32'h0, 6);
    @(negedge clk);
    @(negedge clk);
    chk("busy_in_rd_wait", cpu_ready, 1'b0);
    #1 reset = 1'b1;
    #1 check_reset_outputs("abort");
    resp_q.delete();
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_resp_in_reset", cpu_resp_valid, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    chk("no_resp_after_abort", cpu_resp_valid, 1'b0);
    issue(1'b0, 10'h1D6, 32'h0, 0);
    issue(1'b0, 10'h1D6, 32'h0, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
